switch_port_p: RTL and testbench
================================

Name: switch_port_p

Overview:
- Parametrised next-generation ingress port for the N-port packet switch.
- Buffers incoming {data, target, source} packets in a show-ahead FIFO and classifies the head packet.
- Valid packets request the output arbiter and are transmitted on grant; malformed packets are dropped.
- Adds over the fixed 4-port version: generic port count, data width and FIFO depth; an input ready handshake; a registered output with out_valid; saturating drop, overflow and transmit counters; and multicast/broadcast classification.

Parameters:
- NUM_PORTS, 4: number of switch ports. Source and target fields are NUM_PORTS-bit masks.
- DATA_W, 8: payload width.
- FIFO_DEPTH, 8: FIFO entries. Power of 2, at least 2.
- CNT_W, 16: width of each statistics counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- valid_in  in  1  input packet strobe.
- in_ready  out  1  FIFO can accept a packet this cycle.
- source_in  in  NUM_PORTS  source port mask.
- target_in  in  NUM_PORTS  destination port mask.
- data_in  in  DATA_W  payload.
- grant  in  1  arbiter grant to this port.
- port_req  out  1  arbitration request.
- pkt_dst  out  NUM_PORTS  head packet target mask, to the arbiter.
- out_valid  out  1  out_pkt holds a transmitted packet.
- out_pkt  out  DATA_W+2*NUM_PORTS  {data, target, source}.
- out_type  out  p_type  class of out_pkt.
- drop_cnt  out  CNT_W  malformed packets dropped.
- ovf_cnt  out  CNT_W  pushes rejected because the FIFO was full.
- tx_cnt  out  CNT_W  packets transmitted.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. While rst=1 at a clk edge:
  - FIFO is emptied, so in_ready=1 after reset.
  - State goes to IDLE.
  - port_req=0, out_valid=0, out_pkt=0, out_type=ERR.
  - All counters are cleared.
  - Reset mid-packet discards all buffered packets and any packet awaiting grant.
- Input handshake:
  - A packet is pushed when valid_in && in_ready.
  - in_ready = !full. There is no same-cycle pop bypass, so a push into a full FIFO is rejected even if a pop happens that cycle.
  - valid_in && !in_ready increments ovf_cnt and the packet is discarded.
- FIFO:
  - Show-ahead: the head entry is visible combinationally.
  - Pointers wrap modulo FIFO_DEPTH.
  - A count register of width clog2(FIFO_DEPTH)+1 derives full and empty.
  - Simultaneous push and pop when not full leaves the count unchanged.
- Classification (combinational, on the head entry):
  - ERR if the source is not exactly one-hot, or the target is zero, or (target & source) != 0.
  - Otherwise BC if the target equals all ones except the source bit.
  - Otherwise UC if the target is one-hot.
  - Otherwise MC.
  - pkt_valid = (type != ERR).
- pkt_dst always equals the head target field, whether or not the head is valid.
- State machine, state_t {IDLE, ROUTE, ARB_WAIT, TRANSMIT}:
  - IDLE: go to ROUTE when !empty.
  - ROUTE, one cycle: if pkt_valid go to ARB_WAIT. Otherwise pop the head, increment drop_cnt, and go to ROUTE if the count after the pop is >0, else IDLE.
  - ARB_WAIT: port_req=1. On grant, pop the head, register it into out_pkt/out_type, and go to TRANSMIT. A grant is ignored in every other state.
  - TRANSMIT, one cycle: out_valid=1 and tx_cnt increments. Go to ROUTE if !empty, else IDLE.
- out_valid timing: out_valid is registered and high for exactly the one cycle after the grant cycle. out_pkt holds its value until the next transmit.
- Minimum spacing is 3 cycles per valid packet back-to-back (ROUTE, ARB_WAIT with immediate grant, TRANSMIT).
- Counters saturate at all-ones and do not wrap.
- Pushes accepted during any state are not lost.

Decomposition:
- packet_pkg: state_t, p_type {UC, MC, BC, ERR}, and a classify function parametrised by mask width.
- One sub-module, sync_fifo_p, with parameters WIDTH and DEPTH and signals push, pop, wdata, head, full, empty, count. It resets synchronously, active-high.
- The classifier stays a package function; the FSM and counters live in switch_port_p.

Test Plan:
- Reset → idle: rst for 2 cycles → in_ready=1, port_req=0, out_valid=0, all counters 0.
- Unicast packet: push src=0001, tgt=0100, data=A5; hold grant=1 → port_req high 1 cycle after ROUTE; out_valid one cycle after grant with out_pkt={A5,0100,0001}, out_type=UC; tx_cnt=1.
- Malformed drop: push src=0011, tgt=0100, then push src=0001, tgt=0001 → both dropped with no port_req; drop_cnt=2.
- Multicast and broadcast: src=0001, tgt=0110 → out_type=MC; src=0010, tgt=1101 → out_type=BC.
- Overflow: grant=0, push 10 packets with FIFO_DEPTH=8 → in_ready low after the 8th push; ovf_cnt=2; then grant=1 → exactly 8 transmits, in FIFO order; tx_cnt=8.
- Reset during ARB_WAIT: 3 packets queued, assert rst while port_req=1 → FIFO empty, no out_valid afterwards, counters 0.

Source files
------------

// File: rtl/packet_pkg.sv
// rtl/packet_pkg.sv - shared types and packet classifier for the switch ingress port
// Contents:
//   state_t    ingress FSM states
//   p_type     packet class (UC, MC, BC, ERR)
//   classify   classifies a {source, target} mask pair of a given port count
package packet_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ROUTE    = 2'd1,
    ARB_WAIT = 2'd2,
    TRANSMIT = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    UC  = 2'd0,
    MC  = 2'd1,
    BC  = 2'd2,
    ERR = 2'd3
  } p_type;

  // Masks are zero-extended into this width; the port count must not exceed it.
  localparam int MAX_MASK_W = 32;

  function automatic logic is_onehot(input logic [MAX_MASK_W-1:0] x);
    logic [MAX_MASK_W-1:0] one;
    one = 1;
    return (x != '0) && ((x & (x - one)) == '0);
  endfunction

  // width is the real port count; bits at and above it are expected to be zero.
  function automatic p_type classify(input logic [MAX_MASK_W-1:0] src,
                                     input logic [MAX_MASK_W-1:0] tgt,
                                     input int                    width);
    logic [MAX_MASK_W-1:0] all_m;
    all_m = '0;
    for (int i = 0; i < MAX_MASK_W; i++) begin
      if (i < width) all_m[i] = 1'b1;
    end
    if (!is_onehot(src) || (tgt == '0) || ((tgt & src) != '0)) return ERR;
    // Broadcast is checked before unicast so a 2-port switch reports BC.
    if (tgt == (all_m & ~src)) return BC;
    if (is_onehot(tgt)) return UC;
    return MC;
  endfunction

endpackage

// File: rtl/sync_fifo_p.sv
// rtl/sync_fifo_p.sv - show-ahead synchronous FIFO with occupancy count
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   push, wdata   write strobe and data (ignored when full)
//   pop           read strobe (ignored when empty)
//   head          oldest entry, visible combinationally
//   full, empty   status derived from count
//   count         number of stored entries
module sync_fifo_p #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/switch_port_p.sv
// rtl/switch_port_p.sv - parametrised switch ingress port: buffer, classify, arbitrate, transmit
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   valid_in, in_ready                input packet handshake
//   source_in, target_in, data_in     incoming packet fields
//   grant, port_req, pkt_dst          arbiter interface (pkt_dst = head target)
//   out_valid, out_pkt, out_type      registered transmitted packet {data, target, source}
//   drop_cnt, ovf_cnt, tx_cnt         saturating statistics
module switch_port_p
  import packet_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          valid_in,
  output logic                          in_ready,
  input  logic [NUM_PORTS-1:0]          source_in,
  input  logic [NUM_PORTS-1:0]          target_in,
  input  logic [DATA_W-1:0]             data_in,
  input  logic                          grant,
  output logic                          port_req,
  output logic [NUM_PORTS-1:0]          pkt_dst,
  output logic                          out_valid,
  output logic [DATA_W+2*NUM_PORTS-1:0] out_pkt,
  output p_type                         out_type,
  output logic [CNT_W-1:0]              drop_cnt,
  output logic [CNT_W-1:0]              ovf_cnt,
  output logic [CNT_W-1:0]              tx_cnt
);

  localparam int PKT_W = DATA_W + 2 * NUM_PORTS;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;

  state_t               state;
  logic [PKT_W-1:0]     head;
  logic                 full;
  logic                 empty;
  logic [CW-1:0]        count;
  logic                 push_acc;
  logic                 pop;
  logic [NUM_PORTS-1:0] head_src;
  logic [NUM_PORTS-1:0] head_tgt;
  p_type                head_type;
  logic                 pkt_valid;

  assign in_ready  = !full;
  assign push_acc  = valid_in && !full;
  assign head_src  = head[NUM_PORTS-1:0];
  assign head_tgt  = head[2*NUM_PORTS-1:NUM_PORTS];
  assign head_type = classify(MAX_MASK_W'(head_src), MAX_MASK_W'(head_tgt), NUM_PORTS);
  assign pkt_valid = (head_type != ERR);
  assign pkt_dst   = head_tgt;
  assign port_req  = (state == ARB_WAIT);
  assign pop       = ((state == ROUTE) && !pkt_valid) || ((state == ARB_WAIT) && grant);

  sync_fifo_p #(
    .WIDTH (PKT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_acc),
    .pop   (pop),
    .wdata ({data_in, target_in, source_in}),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_pkt   <= '0;
      out_type  <= ERR;
      drop_cnt  <= '0;
      ovf_cnt   <= '0;
      tx_cnt    <= '0;
    end else begin
      out_valid <= 1'b0;
      // A full FIFO rejects the push even if a pop frees a slot this cycle.
      if (valid_in && full && (ovf_cnt != '1)) ovf_cnt <= ovf_cnt + CNT_W'(1);
      case (state)
        IDLE: begin
          if (!empty) state <= ROUTE;
        end
        ROUTE: begin
          if (pkt_valid) begin
            state <= ARB_WAIT;
          end else begin
            if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
            // Occupancy after this pop, including a concurrent push.
            state <= ((count > CW'(1)) || push_acc) ? ROUTE : IDLE;
          end
        end
        ARB_WAIT: begin
          if (grant) begin
            out_pkt   <= head;
            out_type  <= head_type;
            out_valid <= 1'b1;
            state     <= TRANSMIT;
          end
        end
        TRANSMIT: begin
          if (tx_cnt != '1) tx_cnt <= tx_cnt + CNT_W'(1);
          state <= empty ? IDLE : ROUTE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_switch_port_p.sv
// tb/tb_switch_port_p.sv - scoreboard bench for switch_port_p
module tb_switch_port_p;
  import packet_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic        in_ready;
  logic [3:0]  source_in = '0;
  logic [3:0]  target_in = '0;
  logic [7:0]  data_in = '0;
  logic        grant = 1'b0;
  logic        port_req;
  logic [3:0]  pkt_dst;
  logic        out_valid;
  logic [15:0] out_pkt;
  p_type       out_type;
  logic [15:0] drop_cnt;
  logic [15:0] ovf_cnt;
  logic [15:0] tx_cnt;

  int checks = 0;
  int errors = 0;
  int req_cycles = 0;

  typedef struct {
    logic [15:0] pkt;
    logic [1:0]  typ;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  switch_port_p dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .in_ready  (in_ready),
    .source_in (source_in),
    .target_in (target_in),
    .data_in   (data_in),
    .grant     (grant),
    .port_req  (port_req),
    .pkt_dst   (pkt_dst),
    .out_valid (out_valid),
    .out_pkt   (out_pkt),
    .out_type  (out_type),
    .drop_cnt  (drop_cnt),
    .ovf_cnt   (ovf_cnt),
    .tx_cnt    (tx_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every transmitted packet must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (port_req) req_cycles++;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out_valid actual=%0h required=none", out_pkt);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_pkt", {16'h0, out_pkt}, {16'h0, e.pkt});
          check("out_type", {30'h0, out_type}, {30'h0, e.typ});
        end
      end
    end
  end

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic push(input logic [3:0] src, input logic [3:0] tgt, input logic [7:0] d);
    valid_in  = 1'b1;
    source_in = src;
    target_in = tgt;
    data_in   = d;
    @(posedge clk); #1;
    valid_in  = 1'b0;
  endtask

  task automatic expect_pkt(input logic [3:0] src, input logic [3:0] tgt, input logic [7:0] d,
                            input logic [1:0] typ);
    exp_t e;
    e.pkt = {d, tgt, src};
    e.typ = typ;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=%0d required=0 pending", name, exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, "_in_ready"}, {31'h0, in_ready}, 32'h1);
    check({tag, "_port_req"}, {31'h0, port_req}, 32'h0);
    check({tag, "_out_valid"}, {31'h0, out_valid}, 32'h0);
    check({tag, "_out_pkt"}, {16'h0, out_pkt}, 32'h0);
    check({tag, "_out_type"}, {30'h0, out_type}, {30'h0, ERR});
    check({tag, "_drop_cnt"}, {16'h0, drop_cnt}, 32'h0);
    check({tag, "_ovf_cnt"}, {16'h0, ovf_cnt}, 32'h0);
    check({tag, "_tx_cnt"}, {16'h0, tx_cnt}, 32'h0);
  endtask

  initial begin
    // Reset to idle.
    do_reset(2);
    check_idle_reset("reset");

    // Unicast with grant held: port_req rises two edges after the push edge.
    grant = 1'b1;
    expect_pkt(4'b0001, 4'b0100, 8'hA5, UC);
    push(4'b0001, 4'b0100, 8'hA5);
    check("uc_no_req_idle", {31'h0, port_req}, 32'h0);
    @(posedge clk); #1;
    check("uc_no_req_route", {31'h0, port_req}, 32'h0);
    @(posedge clk); #1;
    check("uc_req", {31'h0, port_req}, 32'h1);
    check("uc_pkt_dst", {28'h0, pkt_dst}, 32'h4);
    @(posedge clk); #1;
    check("uc_out_valid", {31'h0, out_valid}, 32'h1);
    wait_drain("uc", 20);
    check("uc_tx_cnt", {16'h0, tx_cnt}, 32'h1);

    // Malformed packets are dropped without a request.
    req_cycles = 0;
    push(4'b0011, 4'b0100, 8'h11);
    push(4'b0001, 4'b0001, 8'h22);
    repeat (10) @(posedge clk);
    #1;
    check("drop_cnt", {16'h0, drop_cnt}, 32'h2);
    check("drop_no_req", req_cycles, 0);

    // Multicast then broadcast.
    expect_pkt(4'b0001, 4'b0110, 8'h3C, MC);
    expect_pkt(4'b0010, 4'b1101, 8'hC3, BC);
    push(4'b0001, 4'b0110, 8'h3C);
    push(4'b0010, 4'b1101, 8'hC3);
    wait_drain("mcbc", 40);
    check("mcbc_tx_cnt", {16'h0, tx_cnt}, 32'h3);

    // Overflow: ten back-to-back pushes into an eight-entry FIFO with no grant.
    grant = 1'b0;
    do_reset(1);
    for (int i = 0; i < 10; i++) begin
      if (i < 8) expect_pkt(4'b0001, 4'b0010, 8'h10 + 8'(i), UC);
      push(4'b0001, 4'b0010, 8'h10 + 8'(i));
      if (i == 7) check("ovf_in_ready_low", {31'h0, in_ready}, 32'h0);
    end
    check("ovf_cnt", {16'h0, ovf_cnt}, 32'h2);
    check("ovf_no_tx", {16'h0, tx_cnt}, 32'h0);
    grant = 1'b1;
    wait_drain("ovf", 100);
    repeat (5) @(posedge clk);
    #1;
    check("ovf_tx_cnt", {16'h0, tx_cnt}, 32'h8);
    check("ovf_in_ready_back", {31'h0, in_ready}, 32'h1);

    // Reset while a packet awaits grant discards everything.
    grant = 1'b0;
    push(4'b0001, 4'b1000, 8'h01);
    push(4'b0010, 4'b0001, 8'h02);
    push(4'b0100, 4'b0011, 8'h03);
    begin
      int n;
      n = 0;
      while (!port_req && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      check("arb_wait_reached", {31'h0, port_req}, 32'h1);
    end
    do_reset(1);
    check_idle_reset("midreset");
    grant = 1'b1;
    req_cycles = 0;
    repeat (10) @(posedge clk);
    #1;
    check("midreset_no_req", req_cycles, 0);
    check("midreset_tx_cnt", {16'h0, tx_cnt}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
